chunked_adder_sequencer: RTL and testbench
==========================================

# chunked_adder_sequencer

Multi-cycle wide adder controller. Accepts a WIDTH-bit add (optionally subtract) request through a start/ready handshake, then drives one CHUNK-bit parallel-prefix adder slice per cycle, chaining the carry between slices. It presents the full result with carry and signed overflow through a done/ack handshake. The block sits between a requester and the team's prefix-adder datapath, so a narrow adder can serve wide operands.

## Interface
- WIDTH, 32, operand/result width; must be an integer multiple of CHUNK
- CHUNK, 8, bits processed per cycle; NUM_CHUNKS = WIDTH/CHUNK, at least 1
- clock_signal  input  1  single clock, rising edge
- reset_signal  input  1  synchronous, active-high reset
- start_signal  input  1  request; accepted when start_signal & ready_signal at a rising edge
- ready_signal  output  1  high only in IDLE
- first_operand  input  WIDTH  operand A, sampled at acceptance
- second_operand  input  WIDTH  operand B, sampled at acceptance
- carry_in_signal  input  1  carry into chunk 0, sampled at acceptance
- subtract_signal  input  1  present only with SUBTRACT_EN; sampled at acceptance
- result_value  output  WIDTH  sum/difference, valid while done_signal
- carry_out_signal  output  1  carry out of the MSB
- overflow_signal  output  1  signed overflow: carry into MSB XOR carry out of MSB
- done_signal  output  1  result valid, held until acknowledged
- ack_signal  input  1  consumer acknowledge; honoured only while done_signal

## Operation
- FSM states: IDLE, RUN, DONE.
- IDLE: ready_signal=1. On accept, latch A, B, carry-in (and subtract), clear chunk_index, go to RUN.
- RUN: each cycle, slice chunk_index of A and B, plus carry_reg, feeds the sub-adder. At the edge, the sum slice is written to result_reg[chunk_index*CHUNK +: CHUNK] and carry_reg takes the slice carry-out. chunk_index then increments.
- After the edge where chunk_index = NUM_CHUNKS-1: capture carry_out_signal and overflow_signal from the final slice, then go to DONE.
- DONE: done_signal=1. result_value, carry_out_signal and overflow_signal are held constant. On ack_signal=1, go to IDLE.
- Input changes after acceptance are ignored. start_signal is ignored outside IDLE.
- Arithmetic: all widths are unsigned modulo 2^WIDTH. Chunks are combined with no gaps.
- Reset applies from any state: next state IDLE, and all outputs take their reset values. An operation in flight is aborted with no done pulse.
- Reset values: ready_signal=1, done_signal=0, result_value=0, carry_out_signal=0, overflow_signal=0. Internal chunk_index=0 and carry_reg=0.

## Timing
- Acceptance edge T.
- Chunk k is written at edge T+1+k.
- done_signal rises after edge T+NUM_CHUNKS, so latency is NUM_CHUNKS cycles.
- ack sampled at edge D: ready_signal=1 after D. A new accept is possible at edge D+1 at the earliest.
- Throughput: one operation per NUM_CHUNKS+2 cycles with ack held high.
- NUM_CHUNKS=1: RUN lasts one cycle; there is no special case.
- Outputs are registered; there is no combinational path from inputs to outputs except none.

## Configuration
- SUBTRACT_EN defined:
  - subtract_signal port exists.
  - When subtract is latched as 1, B is replaced by ~B and the effective carry-in is 1; carry_in_signal is ignored.
  - carry_out_signal=1 means no borrow.
- SUBTRACT_EN undefined:
  - No subtract_signal port.
  - The block is an adder only, and no inversion logic is built.

## Structure
- Package adder_sequencer_pkg holds:
  - the state enum (IDLE, RUN, DONE);
  - the default WIDTH/CHUNK constants;
  - a function returning the chunk_index width, $clog2(NUM_CHUNKS) with a minimum of 1.
- Sub-module chunk_prefix_adder: combinational, CHUNK-bit Kogge-Stone adder built from generate/propagate prefix nodes.
  - Inputs: A, B, carry-in.
  - Outputs: sum, carry-out, carry into MSB.
  - One instance.

## Test plan
- WIDTH=32/CHUNK=8, 0x000000FF + 0x00000001, cin 0 -> result 0x00000100, carry 0, overflow 0; done exactly 4 cycles after accept.
- 0xFFFFFFFF + 0x00000001 -> result 0x00000000, carry 1, overflow 0; carry ripples through all four chunks.
- 0x7FFFFFFF + 0x00000001 -> result 0x80000000, carry 0, overflow 1.
- SUBTRACT_EN, 0x00000005 - 0x00000007 -> result 0xFFFFFFFE, carry 0 (borrow), overflow 0.
- Reset high during the 2nd RUN cycle -> next cycle ready 1, done 0, result 0; a following 0x10 + 0x20 completes with result 0x30.
- In DONE, hold ack low 10 cycles while toggling operands and start -> result stable, no new accept; ack -> ready 1 next cycle.

Source files
------------

// File: rtl/adder_sequencer_pkg.sv
// Shared types and sizing helpers for the chunked adder sequencer.
package adder_sequencer_pkg;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   localparam int DEFAULT_WIDTH = 32;
   localparam int DEFAULT_CHUNK = 8;

   // Chunk counter width; a single-chunk build still needs one bit.
   function automatic int chunk_index_width(input int num_chunks);
      return (num_chunks <= 1) ? 1 : $clog2(num_chunks);
   endfunction

endpackage

// File: rtl/chunk_prefix_adder.sv
// Combinational CHUNK-bit Kogge-Stone adder; also exposes the carry into the MSB
// so the sequencer can derive signed overflow on the final slice.
module chunk_prefix_adder #(
   parameter int CHUNK = 8
) (
   input  logic [CHUNK-1:0] i_a,
   input  logic [CHUNK-1:0] i_b,
   input  logic             i_cin,
   output logic [CHUNK-1:0] o_sum,
   output logic             o_cout,
   output logic             o_cmsb
);

   // Returns carries into every bit position plus the final carry-out: c[0] = cin.
   function automatic logic [CHUNK:0] prefix_carries(input logic [CHUNK-1:0] a,
                                                     input logic [CHUNK-1:0] b,
                                                     input logic             cin);
      logic [CHUNK-1:0] g, p, gn, pn;
      g = a & b;
      p = a ^ b;
      g[0] = g[0] | (p[0] & cin);
      for (int d = 1; d < CHUNK; d = d * 2) begin
         gn = g;
         pn = p;
         for (int i = d; i < CHUNK; i++) begin
            gn[i] = g[i] | (p[i] & g[i-d]);
            pn[i] = p[i] & p[i-d];
         end
         g = gn;
         p = pn;
      end
      return {g, cin};
   endfunction

   logic [CHUNK:0] w_carry;

   assign w_carry = prefix_carries(i_a, i_b, i_cin);
   assign o_sum   = (i_a ^ i_b) ^ w_carry[CHUNK-1:0];
   assign o_cout  = w_carry[CHUNK];
   assign o_cmsb  = w_carry[CHUNK-1];

endmodule

// File: rtl/chunked_adder_sequencer.sv
// Multi-cycle WIDTH-bit adder: one CHUNK-bit prefix-adder slice per cycle, carry chained.
// Optional subtraction is built only when the SUBTRACT_EN macro is defined.
module chunked_adder_sequencer
   import adder_sequencer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH,
   parameter int CHUNK = DEFAULT_CHUNK
) (
   input  logic             clock_signal,
   input  logic             reset_signal,
   input  logic             start_signal,
   output logic             ready_signal,
   input  logic [WIDTH-1:0] first_operand,
   input  logic [WIDTH-1:0] second_operand,
   input  logic             carry_in_signal,
`ifdef SUBTRACT_EN
   input  logic             subtract_signal,
`endif
   output logic [WIDTH-1:0] result_value,
   output logic             carry_out_signal,
   output logic             overflow_signal,
   output logic             done_signal,
   input  logic             ack_signal
);

   localparam int NUM_CHUNKS = WIDTH / CHUNK;
   localparam int IDX_W      = chunk_index_width(NUM_CHUNKS);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CHUNKS - 1);

   state_t           r_state;
   logic [WIDTH-1:0] r_a;
   logic [WIDTH-1:0] r_b;
   logic [WIDTH-1:0] r_result;
   logic [IDX_W-1:0] r_idx;
   logic             r_carry;
   logic             r_cout;
   logic             r_ovf;
   logic             r_ready;
   logic             r_done;

   logic [CHUNK-1:0] w_a_slice;
   logic [CHUNK-1:0] w_b_slice;
   logic [CHUNK-1:0] w_sum;
   logic             w_cout;
   logic             w_cmsb;
   logic [WIDTH-1:0] w_b_eff;
   logic             w_cin_eff;

`ifdef SUBTRACT_EN
   // Subtraction as A + ~B + 1; carry out of 1 then means no borrow.
   assign w_b_eff   = subtract_signal ? ~second_operand : second_operand;
   assign w_cin_eff = subtract_signal ? 1'b1 : carry_in_signal;
`else
   assign w_b_eff   = second_operand;
   assign w_cin_eff = carry_in_signal;
`endif

   assign w_a_slice = r_a[int'(r_idx)*CHUNK +: CHUNK];
   assign w_b_slice = r_b[int'(r_idx)*CHUNK +: CHUNK];

   chunk_prefix_adder #(.CHUNK(CHUNK)) u_slice_adder (
      .i_a    (w_a_slice),
      .i_b    (w_b_slice),
      .i_cin  (r_carry),
      .o_sum  (w_sum),
      .o_cout (w_cout),
      .o_cmsb (w_cmsb)
   );

   always_ff @(posedge clock_signal) begin
      if (reset_signal) begin
         r_state  <= IDLE;
         r_ready  <= 1'b1;
         r_done   <= 1'b0;
         r_result <= '0;
         r_cout   <= 1'b0;
         r_ovf    <= 1'b0;
         r_idx    <= '0;
         r_carry  <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (start_signal) begin
                  r_a     <= first_operand;
                  r_b     <= w_b_eff;
                  r_carry <= w_cin_eff;
                  r_idx   <= '0;
                  r_ready <= 1'b0;
                  r_state <= RUN;
               end
            end
            RUN: begin
               r_result[int'(r_idx)*CHUNK +: CHUNK] <= w_sum;
               r_carry <= w_cout;
               r_idx   <= r_idx + 1'b1;
               if (r_idx == LAST_IDX) begin
                  r_cout  <= w_cout;
                  r_ovf   <= w_cout ^ w_cmsb;
                  r_done  <= 1'b1;
                  r_state <= DONE;
               end
            end
            DONE: begin
               if (ack_signal) begin
                  r_done  <= 1'b0;
                  r_ready <= 1'b1;
                  r_state <= IDLE;
               end
            end
            default: begin
               r_state <= IDLE;
               r_ready <= 1'b1;
               r_done  <= 1'b0;
            end
         endcase
      end
   end

   assign ready_signal     = r_ready;
   assign done_signal      = r_done;
   assign result_value     = r_result;
   assign carry_out_signal = r_cout;
   assign overflow_signal  = r_ovf;

endmodule

// File: tb/tb_chunked_adder_sequencer.sv
// Directed plus randomized bench for chunked_adder_sequencer (SUBTRACT_EN-aware).
module tb_chunked_adder_sequencer;

   localparam int WIDTH = 32;
   localparam int CHUNK = 8;
   localparam int NC    = WIDTH / CHUNK;

   logic              clock_signal = 1'b0;
   logic              reset_signal;
   logic              start_signal;
   logic              ready_signal;
   logic [WIDTH-1:0]  first_operand;
   logic [WIDTH-1:0]  second_operand;
   logic              carry_in_signal;
   logic              subtract_signal;
   logic [WIDTH-1:0]  result_value;
   logic              carry_out_signal;
   logic              overflow_signal;
   logic              done_signal;
   logic              ack_signal;

   int n_cmp  = 0;
   int n_fail = 0;

   always #5 clock_signal = ~clock_signal;

   chunked_adder_sequencer #(.WIDTH(WIDTH), .CHUNK(CHUNK)) dut (
      .clock_signal     (clock_signal),
      .reset_signal     (reset_signal),
      .start_signal     (start_signal),
      .ready_signal     (ready_signal),
      .first_operand    (first_operand),
      .second_operand   (second_operand),
      .carry_in_signal  (carry_in_signal),
`ifdef SUBTRACT_EN
      .subtract_signal  (subtract_signal),
`endif
      .result_value     (result_value),
      .carry_out_signal (carry_out_signal),
      .overflow_signal  (overflow_signal),
      .done_signal      (done_signal),
      .ack_signal       (ack_signal)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clock_signal);
      #1;
   endtask

   task automatic scramble_inputs();
      first_operand   = $urandom;
      second_operand  = $urandom;
      carry_in_signal = 1'($urandom);
      subtract_signal = 1'($urandom);
   endtask

   // Issues one operation and checks latency, result and handshake against plain arithmetic.
   task automatic run_op(input logic [31:0] a, input logic [31:0] b, input logic cin,
                         input logic sub, input int hold, input string tag);
      logic [31:0] bb;
      logic [32:0] full;
      logic        ov;
      int          k;
      bb   = sub ? ~b : b;
      full = {1'b0, a} + {1'b0, bb} + {32'd0, (sub ? 1'b1 : cin)};
      ov   = (a[31] == bb[31]) && (full[31] != a[31]);

      k = 0;
      while (ready_signal !== 1'b1 && k < 20) begin
         step();
         k++;
      end
      check({tag, " ready_before"}, 64'(ready_signal), 64'd1);

      start_signal    = 1'b1;
      first_operand   = a;
      second_operand  = b;
      carry_in_signal = cin;
      subtract_signal = sub;
      step();
      start_signal = 1'b0;
      scramble_inputs();
      check({tag, " ready_busy"}, 64'(ready_signal), 64'd0);

      for (int c = 1; c <= NC; c++) begin
         step();
         if (c == NC - 1) check({tag, " done_early"}, 64'(done_signal), 64'd0);
      end
      check({tag, " done"},     64'(done_signal),      64'd1);
      check({tag, " result"},   64'(result_value),     64'(full[31:0]));
      check({tag, " carry"},    64'(carry_out_signal), 64'(full[32]));
      check({tag, " overflow"}, 64'(overflow_signal),  64'(ov));

      for (int h = 0; h < hold; h++) begin
         start_signal = 1'($urandom);
         scramble_inputs();
         step();
         check({tag, " hold_result"}, 64'(result_value), 64'(full[31:0]));
         check({tag, " hold_done"},   64'(done_signal),  64'd1);
         check({tag, " hold_ready"},  64'(ready_signal), 64'd0);
      end
      start_signal = 1'b0;

      ack_signal = 1'b1;
      step();
      ack_signal = 1'b0;
      check({tag, " ready_after_ack"}, 64'(ready_signal), 64'd1);
      check({tag, " done_after_ack"},  64'(done_signal),  64'd0);
   endtask

   initial begin
      logic [31:0] ra, rb;
      logic        rc, rs;
      reset_signal    = 1'b1;
      start_signal    = 1'b0;
      ack_signal      = 1'b0;
      first_operand   = '0;
      second_operand  = '0;
      carry_in_signal = 1'b0;
      subtract_signal = 1'b0;
      step();
      step();
      check("reset ready",    64'(ready_signal),     64'd1);
      check("reset done",     64'(done_signal),      64'd0);
      check("reset result",   64'(result_value),     64'd0);
      check("reset carry",    64'(carry_out_signal), 64'd0);
      check("reset overflow", 64'(overflow_signal),  64'd0);
      reset_signal = 1'b0;
      step();

      run_op(32'h000000FF, 32'h00000001, 1'b0, 1'b0, 0, "ff_plus_1");
      run_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, "all_ones_plus_1");
      run_op(32'h7FFFFFFF, 32'h00000001, 1'b0, 1'b0, 0, "max_pos_plus_1");
      run_op(32'h80000000, 32'h80000000, 1'b1, 1'b0, 0, "neg_overflow_cin");
`ifdef SUBTRACT_EN
      run_op(32'h00000005, 32'h00000007, 1'b0, 1'b1, 0, "sub_5_minus_7");
      run_op(32'h00000009, 32'h00000002, 1'b0, 1'b1, 0, "sub_9_minus_2");
`endif

      // Abort in the second RUN cycle via reset.
      start_signal    = 1'b1;
      first_operand   = 32'h12345678;
      second_operand  = 32'h9ABCDEF0;
      carry_in_signal = 1'b1;
      subtract_signal = 1'b0;
      step();
      start_signal = 1'b0;
      step();
      reset_signal = 1'b1;
      step();
      reset_signal = 1'b0;
      check("abort ready",  64'(ready_signal), 64'd1);
      check("abort done",   64'(done_signal),  64'd0);
      check("abort result", 64'(result_value), 64'd0);
      run_op(32'h00000010, 32'h00000020, 1'b0, 1'b0, 0, "after_abort");

      run_op(32'hCAFEBABE, 32'h13572468, 1'b1, 1'b0, 10, "done_hold");

      for (int i = 0; i < 40; i++) begin
         ra = $urandom;
         rb = $urandom;
         rc = 1'($urandom);
`ifdef SUBTRACT_EN
         rs = 1'($urandom);
`else
         rs = 1'b0;
`endif
         run_op(ra, rb, rc, rs, int'($urandom_range(0, 2)), "random");
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end

endmodule
